// File: rtl/game_result_ctrl_if.sv
// Signal bundle between the round-result controller and the rest of the game:
// hit flags and frame/button inputs in, display and detector-control levels out.
interface game_result_ctrl_if;
  logic [1:2] flag;         // sticky hit flags; flag[1] = player1 hit, flag[2] = player2 hit
  logic       frame_tick;   // one-cycle pulse at start of vertical blank
  logic       restart_btn;  // debounced restart button level
  logic       flag_clr;     // clears the detector flags while high
  logic       freeze;       // halts player and bomb movement
  logic       game_over;    // result screen active
  logic [1:0] winner;       // 00 none, 01 player1, 10 player2, 11 draw
  logic       blink;        // banner blink phase

  // Game side: drives the inputs, observes the result outputs
  modport master (
    output flag,
    output frame_tick,
    output restart_btn,
    input  flag_clr,
    input  freeze,
    input  game_over,
    input  winner,
    input  blink
  );

  // Controller side
  modport slave (
    input  flag,
    input  frame_tick,
    input  restart_btn,
    output flag_clr,
    output freeze,
    output game_over,
    output winner,
    output blink
  );
endinterface

// File: rtl/game_result_ctrl.sv
// Round-outcome controller. Watches the sticky hit flags at frame granularity,
// allows a one-frame grace window so near-simultaneous deaths become a draw,
// shows the result for a minimum number of frames with a blinking banner, and
// hands clean flags back to the detector before the next round starts.
module game_result_ctrl #(
  parameter int unsigned HOLD_FRAMES  = 120,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input logic              clk,
  input logic              reset,
  game_result_ctrl_if.slave bus
);

  localparam int unsigned HoldW  = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [HoldW-1:0]  HoldMax  = HoldW'(HOLD_FRAMES);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    StClear  = 2'd0,
    StPlay   = 2'd1,
    StSettle = 2'd2,
    StResult = 2'd3
  } state_e;

  state_e            state;
  logic [1:0]        win_code;
  logic [HoldW-1:0]  hold_cnt;
  logic [BlinkW-1:0] blink_cnt;
  logic              blink_phase;
  logic              btn_q;
  logic [1:2]        pend;

  logic              press;
  logic              flags_idle;
  logic              hold_done;
  logic [1:2]        final_hits;

  assign press      = bus.restart_btn & ~btn_q;
  assign flags_idle = (bus.flag == 2'b00);
  assign hold_done  = (hold_cnt == HoldMax);
  // Hits seen during the grace window plus whatever is present on the deciding tick
  assign final_hits = pend | bus.flag;

  // Surviving player wins; both hit is a draw
  function automatic logic [1:0] map_winner(input logic [1:2] hits);
    logic [1:0] code;
    code = 2'b00;
    if (hits[1] && hits[2]) begin
      code = 2'b11;
    end else if (hits[1]) begin
      code = 2'b10;
    end else if (hits[2]) begin
      code = 2'b01;
    end
    return code;
  endfunction

  // Round sequencing, result latch, hold/blink counters and restart edge detector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StClear;
      win_code    <= 2'b00;
      hold_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      btn_q       <= 1'b0;
      pend        <= 2'b00;
    end else begin
      btn_q <= bus.restart_btn;
      case (state)
        // Flags are being cleared; a held button or stale flags keep us here
        StClear: begin
          if (bus.frame_tick && flags_idle && !bus.restart_btn) begin
            state    <= StPlay;
            win_code <= 2'b00;
          end
        end

        // Only judge flags on frame boundaries so a scanned hit is complete
        StPlay: begin
          if (bus.frame_tick && !flags_idle) begin
            pend  <= bus.flag;
            state <= StSettle;
          end
        end

        StSettle: begin
          if (bus.frame_tick) begin
            win_code    <= map_winner(final_hits);
            hold_cnt    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            state       <= StResult;
          end else begin
            pend <= final_hits;
          end
        end

        // Press is judged on the pre-increment hold count; early presses are dropped
        StResult: begin
          if (press && hold_done) begin
            state       <= StClear;
            blink_phase <= 1'b0;
          end else if (bus.frame_tick) begin
            if (!hold_done) begin
              hold_cnt <= hold_cnt + HoldW'(1);
            end
            if (blink_cnt == BlinkMax) begin
              blink_cnt   <= '0;
              blink_phase <= ~blink_phase;
            end else begin
              blink_cnt <= blink_cnt + BlinkW'(1);
            end
          end
        end

        default: begin
          state       <= StClear;
          blink_phase <= 1'b0;
        end
      endcase
    end
  end

  // Level outputs decoded straight from the round state
  always_comb begin
    bus.flag_clr  = 1'b0;
    bus.freeze    = 1'b0;
    bus.game_over = 1'b0;
    case (state)
      StClear: begin
        bus.flag_clr = 1'b1;
        bus.freeze   = 1'b1;
      end
      StResult: begin
        bus.freeze    = 1'b1;
        bus.game_over = 1'b1;
      end
      default: begin
        bus.flag_clr  = 1'b0;
        bus.freeze    = 1'b0;
        bus.game_over = 1'b0;
      end
    endcase
  end

  assign bus.winner = win_code;
  assign bus.blink  = blink_phase;

endmodule

// File: tb/tb_game_result_ctrl.sv
// Bench for game_result_ctrl with short hold/blink periods. A round-level model
// predicts every output; a negedge process compares it each cycle, and literal
// expectations at key points pin the model.
module tb_game_result_ctrl;

  localparam int unsigned HoldFrames  = 4;
  localparam int unsigned BlinkFrames = 2;

  localparam int MClear = 0;
  localparam int MPlay  = 1;
  localparam int MGrace = 2;
  localparam int MShow  = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  game_result_ctrl_if bus ();

  game_result_ctrl #(
    .HOLD_FRAMES (HoldFrames),
    .BLINK_FRAMES(BlinkFrames)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Round-level model
  int   m_mode   = MClear;
  logic m_g1     = 1'b0;
  logic m_g2     = 1'b0;
  logic [1:0] m_winner = 2'b00;
  int   m_frames = 0;
  logic m_btn_prev = 1'b0;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode     = MClear;
    m_g1       = 1'b0;
    m_g2       = 1'b0;
    m_winner   = 2'b00;
    m_frames   = 0;
    m_btn_prev = 1'b0;
  endtask

  task automatic model_update(input logic p1, input logic p2, input logic tick, input logic btn);
    logic press;
    logic f1;
    logic f2;
    press = btn && !m_btn_prev;
    case (m_mode)
      MClear: if (tick && !p1 && !p2 && !btn) begin
        m_mode   = MPlay;
        m_winner = 2'b00;
      end
      MPlay: if (tick && (p1 || p2)) begin
        m_mode = MGrace;
        m_g1   = p1;
        m_g2   = p2;
      end
      MGrace: begin
        f1 = m_g1 | p1;
        f2 = m_g2 | p2;
        if (tick) begin
          // Whoever was not hit wins
          m_winner = (f1 && f2) ? 2'b11 : (f1 ? 2'b10 : 2'b01);
          m_frames = 0;
          m_mode   = MShow;
        end else begin
          m_g1 = f1;
          m_g2 = f2;
        end
      end
      default: begin
        if (press && m_frames >= HoldFrames) m_mode = MClear;
        else if (tick) m_frames++;
      end
    endcase
    m_btn_prev = btn;
  endtask

  function automatic logic exp_blink();
    return (m_mode == MShow) && (((m_frames / BlinkFrames) % 2) == 0);
  endfunction

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("flag_clr",  {1'b0, bus.flag_clr},  {1'b0, m_mode == MClear});
    chk("freeze",    {1'b0, bus.freeze},    {1'b0, (m_mode == MClear) || (m_mode == MShow)});
    chk("game_over", {1'b0, bus.game_over}, {1'b0, m_mode == MShow});
    chk("winner",    bus.winner,            m_winner);
    chk("blink",     {1'b0, bus.blink},     {1'b0, exp_blink()});
  end

  // One clock of stimulus; inputs change 1 ns after the active edge
  task automatic step(input logic p1, input logic p2, input logic tick, input logic btn);
    bus.flag[1]     = p1;
    bus.flag[2]     = p2;
    bus.frame_tick  = tick;
    bus.restart_btn = btn;
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else model_update(p1, p2, tick, btn);
  endtask

  task automatic idle(input int n, input logic p1, input logic p2, input logic btn);
    repeat (n) step(p1, p2, 1'b0, btn);
  endtask

  task automatic lit(input string name, input logic [1:0] act, input logic [1:0] exp);
    chk(name, act, exp);
  endtask

  initial begin
    reset           = 1'b1;
    bus.flag        = 2'b00;
    bus.frame_tick  = 1'b0;
    bus.restart_btn = 1'b0;
    model_reset();

    // Reset held for three cycles
    idle(3, 1'b0, 1'b0, 1'b0);
    lit("rst_flag_clr", {1'b0, bus.flag_clr}, 2'd1);
    lit("rst_freeze", {1'b0, bus.freeze}, 2'd1);
    reset = 1'b0;
    idle(2, 1'b0, 1'b0, 1'b0);
    lit("post_rst_flag_clr", {1'b0, bus.flag_clr}, 2'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    lit("play_outputs", {bus.flag_clr, bus.freeze}, 2'b00);
    lit("play_game_over", {1'b0, bus.game_over}, 2'd0);
    lit("play_winner", bus.winner, 2'b00);

    // Player1 hit: flag appears mid-frame, judged on tick, decided one tick later
    idle(2, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    lit("settle_no_freeze", {1'b0, bus.freeze}, 2'd0);
    idle(3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    lit("p1hit_winner", bus.winner, 2'b10);
    lit("p1hit_over", {bus.game_over, bus.freeze}, 2'b11);
    lit("p1hit_blink", {1'b0, bus.blink}, 2'd1);

    // Hold and blink: early press ignored, later press accepted
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    lit("blink_after_2", {1'b0, bus.blink}, 2'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    lit("early_press", {1'b0, bus.game_over}, 2'd1);
    idle(1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    lit("blink_after_4", {1'b0, bus.blink}, 2'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    lit("restart_clr", {bus.flag_clr, bus.game_over}, 2'b10);
    lit("restart_winner_kept", bus.winner, 2'b10);
    lit("restart_blink", {1'b0, bus.blink}, 2'd0);

    // CLEAR exit gating: stale flag, then held button, then release with tick
    repeat (3) begin
      idle(2, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
    end
    lit("stale_flag_clear", {1'b0, bus.flag_clr}, 2'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    lit("held_btn_clear", {1'b0, bus.flag_clr}, 2'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    lit("clear_exit", {bus.flag_clr, bus.freeze}, 2'b00);
    lit("clear_exit_winner", bus.winner, 2'b00);

    // Draw: player2 hit at tick, player1 hit inside the grace frame
    idle(2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    lit("draw_winner", bus.winner, 2'b11);

    // Press coinciding with tick at hold_cnt = HOLD-1 is judged pre-increment
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    lit("press_with_tick", {1'b0, bus.game_over}, 2'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    lit("held_not_press", {1'b0, bus.game_over}, 2'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    lit("second_press", {1'b0, bus.flag_clr}, 2'd1);

    // Player2-only round, then async reset mid-result with both flags up
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    lit("p2hit_winner", bus.winner, 2'b01);
    idle(1, 1'b0, 1'b1, 1'b0);
    bus.flag = 2'b11;
    reset    = 1'b1;
    #1;
    model_reset();
    lit("async_game_over", {1'b0, bus.game_over}, 2'd0);
    lit("async_flag_clr", {1'b0, bus.flag_clr}, 2'd1);
    lit("async_winner", bus.winner, 2'b00);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    lit("stale_after_rst", {bus.flag_clr, bus.game_over}, 2'b10);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    lit("replay_after_rst", {bus.flag_clr, bus.freeze}, 2'b00);
    idle(3, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/game_result_ctrl.md
Name: game_result_ctrl

Overview:
- Consumes the sticky per-player hit flags produced by the explosion/player overlap detector.
- Decides the round outcome at frame granularity: win, loss or draw.
- Freezes gameplay and drives the result display (game_over, winner, blink).
- Handles the restart handshake, and owns the flag clear back to the detector so a new round starts with clean flags.

Parameters:
- HOLD_FRAMES, 120: minimum frames the result is shown before restart is accepted.
- BLINK_FRAMES, 30: frames per blink half-period of the result banner.

Ports:
- clk  input  1  system clock (pixel clock domain)
- reset  input  1  asynchronous, active-high reset
- flag  input  [1:2]  sticky hit flags; bit1 = player1 hit, bit2 = player2 hit
- frame_tick  input  1  one-cycle pulse at start of vertical blank
- restart_btn  input  1  debounced restart button level
- flag_clr  output  1  level; clears detector flags while high
- freeze  output  1  level; halts player and bomb movement
- game_over  output  1  level; result screen active
- winner  output  [1:0]  00 none, 01 player1 wins, 10 player2 wins, 11 draw
- blink  output  1  banner blink phase

Behaviour:
- One clock (clk). Reset is asynchronous and active-high.
- Reset state and outputs:
  - state=CLEAR, winner=00, hold_cnt=0, blink_cnt=0, btn_q=0.
  - Outputs: flag_clr=1, freeze=1, game_over=0, blink=0.
  - Rationale: the detector has no reset of its own, so flags must be cleared after every reset.
- flag_clr, freeze and game_over are decoded from state. winner, blink and the counters are registered.
- flag, restart_btn and frame_tick are all sampled on posedge clk.
- Restart edge detection: btn_q is registered restart_btn. A press is restart_btn=1 with btn_q=0.
- CLEAR:
  - Outputs: flag_clr=1, freeze=1.
  - On frame_tick with flag==00 and restart_btn==0: go to PLAY and set winner=00.
  - Otherwise stay in CLEAR. A held button keeps the block in CLEAR.
- PLAY:
  - Outputs: all low.
  - On frame_tick with flag!=00: latch pend=flag and go to SETTLE.
  - flag!=00 between ticks is ignored until the next tick. A pixel-scanned hit completes within its frame.
- SETTLE (one-frame grace window so near-simultaneous deaths become a draw):
  - Outputs: freeze=0.
  - Every cycle: pend |= flag.
  - On the next frame_tick, compute final=pend|flag and map it to winner: 01→10, 10→01, 11→11.
  - On that same tick, clear hold_cnt and blink_cnt, set blink=1, and go to RESULT.
- RESULT:
  - Outputs: freeze=1, game_over=1. winner is held.
  - On each frame_tick, hold_cnt increments and saturates at HOLD_FRAMES.
  - blink_cnt wraps at BLINK_FRAMES-1; blink toggles on wrap.
  - Restart press with hold_cnt==HOLD_FRAMES: go to CLEAR and set blink=0. winner is kept until PLAY entry.
  - Restart press with hold_cnt<HOLD_FRAMES: ignored and not queued. The user must release and press again.
  - Press and frame_tick in the same cycle: the press is judged against the pre-increment hold_cnt.
- Counter widths: hold_cnt uses clog2(HOLD_FRAMES+1) bits; blink_cnt uses clog2(BLINK_FRAMES) bits (minimum 1).
- Illegal state encoding: recover to CLEAR.
- Reset mid-SETTLE or mid-RESULT: immediate return to CLEAR. Stale flags must not retrigger game over.

Test Plan:
- Reset: assert reset 3 cycles; hold flag=00 and restart_btn=0; apply tick → flag_clr=1 and freeze=1 during and after reset; on the tick, PLAY with all outputs 0 and winner=00.
- Player1 hit: in PLAY, flag=01 before tick N; tick N+1 → winner=10, game_over=1, freeze=1, blink=1.
- Draw within grace window: flag=10 at tick N, flag=11 mid-frame, tick N+1 → winner=11.
- Hold and blink (HOLD_FRAMES=4, BLINK_FRAMES=2):
  - Press after 2 ticks → stays in RESULT.
  - Release, 2 more ticks, press → CLEAR with flag_clr=1.
  - blink toggles every 2 ticks.
- CLEAR exit gating: flag held at 01 for 3 ticks → stays in CLEAR; flag=00 with button held → stays; button released plus tick → PLAY with winner=00.
- Async reset mid-RESULT with flag=11 still asserted → CLEAR immediately, game_over=0, flag_clr=1; no new result until flags clear.
